// File: rtl/video_timing_gen.sv
// Raster timing generator with built-in test patterns.
// Every output is registered from the current (h,v) on each PIX_CE edge, so outputs lag the counters by one pixel.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC_W = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC_W = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PIX_CE,
  input  logic [1:0]         MODE,
  output logic               H_SYNC,
  output logic               V_SYNC,
  output logic               DE,
  output logic [11:0]        PIX_X,
  output logic [11:0]        PIX_Y,
  output logic [COLOR_W-1:0] RED,
  output logic [COLOR_W-1:0] GREEN,
  output logic [COLOR_W-1:0] BLUE,
  output logic               LINE_START,
  output logic               FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC_W + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] H_ACT_M1 = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_ACT_M1 = 12'(V_ACTIVE - 1);
  // Sync windows are half-open; the back porch (>=1) keeps the end below 4096.
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC_W);
  localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC_W);
  localparam logic [11:0] BAR_W    = 12'(H_ACTIVE / 8);

  logic [11:0] h_q, h_d, v_q, v_d;
  logic [1:0]  mode_q, mode_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        ls_q, ls_d, fs_q, fs_d;

  logic        at_origin;
  logic        grid_on;
  logic [2:0]  bar_idx;
  logic [2:0]  pat;

  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    mode_d    = mode_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    de_d      = de_q;
    x_d       = x_q;
    y_d       = y_q;
    rgb_d     = rgb_q;
    ls_d      = 1'b0;
    fs_d      = 1'b0;
    at_origin = (h_q == 12'd0) && (v_q == 12'd0);
    grid_on   = (h_q[4:0] == 5'd0) || (v_q[4:0] == 5'd0) ||
                (h_q == H_ACT_M1) || (v_q == V_ACT_M1);
    bar_idx   = 3'(h_q / BAR_W);
    pat       = 3'b000;

    if (PIX_CE) begin
      // The origin pixel already uses the newly sampled mode.
      mode_d = at_origin ? MODE : mode_q;

      if (h_q == H_LAST) begin
        h_d = 12'd0;
        v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
      end else begin
        h_d = h_q + 12'd1;
      end

      unique case (mode_d)
        2'b00: pat = 3'b100;
        2'b01: begin
          unique case (bar_idx)
            3'd0: pat = 3'b111;
            3'd1: pat = 3'b110;
            3'd2: pat = 3'b011;
            3'd3: pat = 3'b010;
            3'd4: pat = 3'b101;
            3'd5: pat = 3'b100;
            3'd6: pat = 3'b001;
            3'd7: pat = 3'b000;
          endcase
        end
        2'b10: pat = {3{h_q[5] ^ v_q[5]}};
        2'b11: pat = {3{grid_on}};
      endcase

      hs_d  = (h_q >= HS_BEG && h_q < HS_END) ? HS_POL : ~HS_POL;
      vs_d  = (v_q >= VS_BEG && v_q < VS_END) ? VS_POL : ~VS_POL;
      de_d  = (h_q < H_ACT) && (v_q < V_ACT);
      x_d   = h_q;
      y_d   = v_q;
      rgb_d = de_d ? pat : 3'b000;
      ls_d  = (h_q == 12'd0);
      fs_d  = at_origin;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_q    <= 12'd0;
      v_q    <= 12'd0;
      mode_q <= 2'b00;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      de_q   <= 1'b0;
      x_q    <= 12'd0;
      y_q    <= 12'd0;
      rgb_q  <= 3'b000;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      mode_q <= mode_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      x_q    <= x_d;
      y_q    <= y_d;
      rgb_q  <= rgb_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign H_SYNC      = hs_q;
  assign V_SYNC      = vs_q;
  assign DE          = de_q;
  assign PIX_X       = x_q;
  assign PIX_Y       = y_q;
  assign RED         = {COLOR_W{rgb_q[2]}};
  assign GREEN       = {COLOR_W{rgb_q[1]}};
  assign BLUE        = {COLOR_W{rgb_q[0]}};
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen against a pixel-index reference model.
module tb_video_timing_gen;

  localparam int HA = 64, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 40, VFP = 2, VSW = 3, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b0;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET, PIX_CE;
  logic [1:0]    MODE;
  logic          H_SYNC, V_SYNC, DE, LINE_START, FRAME_START;
  logic [11:0]   PIX_X, PIX_Y;
  logic [CW-1:0] RED, GREEN, BLUE;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: linear pixel index within the frame plus the latched mode.
  int         p;
  logic [1:0] m_mode;
  logic       e_hs, e_vs, e_de, e_ls, e_fs;
  int         e_x, e_y;
  logic [11:0] e_rgb;

  logic [2:0] bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC_W(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC_W(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .COLOR_W(CW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PIX_CE(PIX_CE), .MODE(MODE),
    .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .DE(DE),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t (model pixel %0d)", tag, got, exp, $time, p);
    end
  endtask

  function automatic logic [11:0] ref_color(input int h, input int v, input logic [1:0] m);
    logic [2:0] on;
    bit grid;
    grid = (h % 32 == 0) || (v % 32 == 0) || (h == HA - 1) || (v == VA - 1);
    case (m)
      2'd0:    on = 3'b100;
      2'd1:    on = bar_tab[h / (HA / 8)];
      2'd2:    on = (((h / 32) % 2) != ((v / 32) % 2)) ? 3'b111 : 3'b000;
      default: on = grid ? 3'b111 : 3'b000;
    endcase
    return {on[2] ? 4'hF : 4'h0, on[1] ? 4'hF : 4'h0, on[0] ? 4'hF : 4'h0};
  endfunction

  task automatic model_step();
    int h, v;
    if (RESET) begin
      p = 0; m_mode = 2'd0;
      e_hs = !HSP; e_vs = !VSP; e_de = 1'b0;
      e_x = 0; e_y = 0; e_rgb = 12'd0; e_ls = 1'b0; e_fs = 1'b0;
    end else if (PIX_CE) begin
      h = p % HT;
      v = p / HT;
      if (p == 0) m_mode = MODE;
      e_x   = h;
      e_y   = v;
      e_hs  = (h >= HA + HFP && h < HA + HFP + HSW) ? HSP : !HSP;
      e_vs  = (v >= VA + VFP && v < VA + VFP + VSW) ? VSP : !VSP;
      e_de  = (h < HA) && (v < VA);
      e_rgb = e_de ? ref_color(h, v, m_mode) : 12'd0;
      e_ls  = (h == 0);
      e_fs  = (p == 0);
      p = (p + 1) % FRAME;
    end else begin
      e_ls = 1'b0;
      e_fs = 1'b0;
    end
  endtask

  task automatic cycle(input logic rst, input logic ce, input logic [1:0] md);
    RESET  = rst;
    PIX_CE = ce;
    MODE   = md;
    @(posedge CLK);
    model_step();
    #1;
    check_val("hsync", 32'(H_SYNC), 32'(e_hs));
    check_val("vsync", 32'(V_SYNC), 32'(e_vs));
    check_val("de", 32'(DE), 32'(e_de));
    check_val("pix_x", 32'(PIX_X), 32'(e_x));
    check_val("pix_y", 32'(PIX_Y), 32'(e_y));
    check_val("rgb", 32'({RED, GREEN, BLUE}), 32'(e_rgb));
    check_val("line_start", 32'(LINE_START), 32'(e_ls));
    check_val("frame_start", 32'(FRAME_START), 32'(e_fs));
  endtask

  initial begin
    logic [1:0] md;
    int rst_left;
    RESET = 1'b1; PIX_CE = 1'b0; MODE = 2'd0;
    p = 0; m_mode = 2'd0;

    // Reset with and without pixel enable.
    cycle(1'b1, 1'b0, 2'd0);
    cycle(1'b1, 1'b0, 2'd0);
    cycle(1'b1, 1'b1, 2'd3);
    cycle(1'b1, 1'b1, 2'd1);

    // Continuous enable, mode rewritten mid-frame.
    md = 2'd0;
    for (int i = 0; i < 2 * FRAME + 200; i++) begin
      if (i % 1300 == 650) md = 2'($urandom_range(0, 3));
      cycle(1'b0, 1'b1, md);
    end

    // Sparse then random enable.
    for (int i = 0; i < 16000; i++) begin
      if ($urandom_range(0, 299) == 0) md = 2'($urandom_range(0, 3));
      if (i < 6000) cycle(1'b0, (i % 4) == 0, md);
      else          cycle(1'b0, 1'($urandom_range(0, 1)), md);
    end

    // Random reset pulses at arbitrary positions.
    rst_left = 0;
    for (int i = 0; i < 8000; i++) begin
      if (rst_left == 0 && $urandom_range(0, 999) == 0) rst_left = $urandom_range(1, 3);
      if ($urandom_range(0, 199) == 0) md = 2'($urandom_range(0, 3));
      cycle(rst_left != 0, ($urandom_range(0, 3) != 0), md);
      if (rst_left != 0) rst_left--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters (name, default, meaning):
- H_ACTIVE 640: visible pixels per line.
- H_FP 16: horizontal front porch.
- H_SYNC_W 96: horizontal sync width.
- H_BP 48: horizontal back porch.
- V_ACTIVE 480: visible lines.
- V_FP 10: vertical front porch.
- V_SYNC_W 2: vertical sync width.
- V_BP 33: vertical back porch.
- HS_POL 0: asserted level of H_SYNC.
- VS_POL 0: asserted level of V_SYNC.
- COLOR_W 4: bits per colour channel.

REQ-002 Ports (name, direction, width, meaning):
- CLK in 1: single clock.
- RESET in 1: synchronous reset, active-high.
- PIX_CE in 1: pixel clock enable.
- MODE in 2: test-pattern select.
- H_SYNC out 1: horizontal sync.
- V_SYNC out 1: vertical sync.
- DE out 1: active-video flag.
- PIX_X out 12: output column.
- PIX_Y out 12: output line.
- RED, GREEN, BLUE out COLOR_W each: pixel colour.
- LINE_START out 1: strobe.
- FRAME_START out 1: strobe.

REQ-003 Parameter limits: every porch/sync parameter >=1; H_TOTAL = H_ACTIVE+H_FP+H_SYNC_W+H_BP <= 4096; V_TOTAL likewise <= 4096; H_ACTIVE multiple of 8.

Function
REQ-004 Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) advance only on CLK edges with PIX_CE=1; PIX_CE=0 freezes counters and all outputs.
REQ-005 h wraps H_TOTAL-1 -> 0 and increments v; v wraps V_TOTAL-1 -> 0 when h wraps at v=V_TOTAL-1.
REQ-006 Region order per line: active [0,H_ACTIVE), front porch, sync, back porch; per frame: same order for v.
REQ-007 All outputs are registered from the current (h,v) on the same PIX_CE edge that advances the counters; all outputs are mutually aligned, one PIX_CE cycle of latency; PIX_X=h and PIX_Y=v of that pixel.
REQ-008 H_SYNC = HS_POL when h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC_W-1], else ~HS_POL; V_SYNC is defined the same way on v using V_FP, V_SYNC_W, VS_POL, independent of h.
REQ-009 DE = 1 when h<H_ACTIVE and v<V_ACTIVE.
REQ-010 LINE_START = 1 for exactly one CLK cycle when the output shows h=0; FRAME_START = 1 for exactly one CLK cycle when the output shows (0,0); both are 0 on PIX_CE=0 cycles.
REQ-011 MODE is latched into an internal mode register only on the PIX_CE edge that produces (0,0); mid-frame MODE changes take effect from the next frame.
REQ-012 Patterns (full-scale F = all ones), by mode register value:
- 00: solid red, R=F, G=0, B=0.
- 01: 8 vertical bars, bar index = h/(H_ACTIVE/8); order white, yellow, cyan, green, magenta, red, blue, black.
- 10: checker; white when h[5] xor v[5], else black.
- 11: grid; white when h[4:0]=0 or v[4:0]=0 or h=H_ACTIVE-1 or v=V_ACTIVE-1, else black.
REQ-013 RGB = 0 whenever DE=0.

Reset
REQ-014 RESET=1 at a CLK edge, regardless of PIX_CE:
- h=0, v=0, mode register=00.
- H_SYNC=~HS_POL, V_SYNC=~VS_POL.
- DE=0, PIX_X=0, PIX_Y=0, RGB=0, LINE_START=0, FRAME_START=0.
REQ-015 Reset mid-line or mid-frame aborts the current position with no partial sync pulse held over.
REQ-016 After RESET deasserts, the first PIX_CE edge outputs (0,0) with DE=1 and FRAME_START=1.

Verification
REQ-017 Defaults, PIX_CE=1, release reset: the first edge shows X=0, Y=0, DE=1, FRAME_START=1, R=F; LINE_START period is 800 cycles; H_SYNC is low for exactly 96 cycles, starting at PIX_X=656.
REQ-018 Defaults, full frame: V_SYNC is low exactly while PIX_Y is 490-491 (1600 cycles); FRAME_START period is 420000 cycles; DE is high for 307200 cycles per frame.
REQ-019 PIX_CE high 1 cycle in 4: all periods scale by 4; outputs are stable on PIX_CE=0 cycles; strobes are one CLK wide.
REQ-020 MODE 00 -> 01 at (300,100): the remainder of the frame stays R=F, G=0, B=0; the next frame shows x 0-79 white, 80-159 yellow (R=F, G=F, B=0), and 560-639 black.
REQ-021 RESET pulsed at (300,100): the next edge gives the reset values; after release, output resumes at (0,0) with FRAME_START=1.
REQ-022 HS_POL=1, VS_POL=1: H_SYNC is high only at PIX_X 656-751, and V_SYNC is high only at PIX_Y 490-491.
